// File: rtl/stitch_raster_ctrl.sv
// rtl/stitch_raster_ctrl.sv - VGA raster timing, stitch cell coordinates, frame-aligned config handshake
//
// Generates sync/blanking from free-running hcount/vcount, splits the visible
// area into square cells of 2**CELL_LOG2 pixels, and holds a one-deep
// configuration slot that is only promoted to cfg_active at the frame
// boundary (first blanked line, hcount = 0).
//
// Optional feature macro: STITCH_ANIM_EN
//   defined   - 8-bit frame counter, increments at each frame boundary
//   undefined - frame is tied to 8'h00, no counter flops
//
// Ports:
//   clk, rst            pixel clock, asynchronous active-high reset
//   cfg_valid/cfg_data  configuration byte offered by the sender
//   cfg_ready           pending slot empty
//   cfg_active          configuration in force for the current frame
//   hsync, vsync        active-low syncs
//   display_on          pixel inside the visible area
//   cell_x/cell_y       cell column/row (0 outside the visible area)
//   sub_x/sub_y         pixel within cell (0 outside the visible area)
//   frame, frame_start  frame counter and one-cycle start-of-frame pulse
// All outputs are registered: they reflect the counters of the previous cycle.
module stitch_raster_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CELL_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    input  logic [7:0] cfg_data,
    output logic       cfg_ready,
    output logic [7:0] cfg_active,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [5:0] cell_x,
    output logic [4:0] cell_y,
    output logic [3:0] sub_x,
    output logic [3:0] sub_y,
    output logic [7:0] frame,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] SUB_MASK = 10'((1 << CELL_LOG2) - 1);

    typedef enum logic {
        CFG_EMPTY = 1'b0,
        CFG_FULL  = 1'b1
    } cfg_state_t;

    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       visible;
    logic       boundary;
    logic       top_left;

    cfg_state_t state_q;
    cfg_state_t state_d;
    logic       pend_load;
    logic       pend_apply;
    logic [7:0] pending;

    // Raster counters; vcount steps only on the hcount wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end else begin
            hcount <= hcount + 10'd1;
        end
    end

    assign visible  = (hcount < H_VIS) && (vcount < V_VIS);
    assign boundary = (hcount == 10'd0) && (vcount == V_VIS);
    assign top_left = (hcount == 10'd0) && (vcount == 10'd0);

    // Decoded outputs, registered once so every output shares the same latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            display_on  <= 1'b0;
            frame_start <= 1'b0;
            cell_x      <= '0;
            cell_y      <= '0;
            sub_x       <= '0;
            sub_y       <= '0;
        end else begin
            hsync       <= !((hcount >= HS_BEG) && (hcount <= HS_END));
            vsync       <= !((vcount >= VS_BEG) && (vcount <= VS_END));
            display_on  <= visible;
            frame_start <= top_left;
            cell_x      <= visible ? 6'(hcount >> CELL_LOG2) : 6'd0;
            cell_y      <= visible ? 5'(vcount >> CELL_LOG2) : 5'd0;
            sub_x       <= visible ? 4'(hcount & SUB_MASK) : 4'd0;
            sub_y       <= visible ? 4'(vcount & SUB_MASK) : 4'd0;
        end
    end

    // Handshake: an accept in the boundary cycle lands in pending and waits
    // for the next boundary; there is no path straight into cfg_active.
    always_comb begin
        state_d    = state_q;
        pend_load  = 1'b0;
        pend_apply = 1'b0;
        case (state_q)
            CFG_EMPTY: begin
                if (cfg_valid) begin
                    pend_load = 1'b1;
                    state_d   = CFG_FULL;
                end
            end
            CFG_FULL: begin
                if (boundary) begin
                    pend_apply = 1'b1;
                    state_d    = CFG_EMPTY;
                end
            end
            default: state_d = CFG_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CFG_EMPTY;
            pending    <= '0;
            cfg_active <= '0;
        end else begin
            state_q <= state_d;
            if (pend_load)
                pending <= cfg_data;
            if (pend_apply)
                cfg_active <= pending;
        end
    end

    assign cfg_ready = (state_q == CFG_EMPTY);

`ifdef STITCH_ANIM_EN
    logic [7:0] frame_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_q <= '0;
        else if (boundary)
            frame_q <= frame_q + 8'd1;
    end

    assign frame = frame_q;
`else
    assign frame = 8'h00;
`endif

endmodule

// File: tb/tb_stitch_raster_ctrl.sv
// tb/tb_stitch_raster_ctrl.sv - directed self-checking bench for stitch_raster_ctrl
module tb_stitch_raster_ctrl;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 48, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 80
    localparam int VT = VA + VF + VS + VB;   // 55
    localparam int FT = HT * VT;             // 4400
`ifdef STITCH_ANIM_EN
    localparam int ANIM = 1;
`else
    localparam int ANIM = 0;
`endif

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic [7:0] cfg_data;
    logic       cfg_ready;
    logic [7:0] cfg_active;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic [5:0] cell_x;
    logic [4:0] cell_y;
    logic [3:0] sub_x;
    logic [3:0] sub_y;
    logic [7:0] frame;
    logic       frame_start;

    int vectors;
    int miscompares;
    int abs_pos;

    stitch_raster_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CELL_LOG2(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_valid(cfg_valid),
        .cfg_data(cfg_data),
        .cfg_ready(cfg_ready),
        .cfg_active(cfg_active),
        .hsync(hsync),
        .vsync(vsync),
        .display_on(display_on),
        .cell_x(cell_x),
        .cell_y(cell_y),
        .sub_x(sub_x),
        .sub_y(sub_y),
        .frame(frame),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // abs_pos = linear raster position whose decode is currently on the outputs
    function automatic int pos(input int f, input int v, input int h);
        return f * FT + v * HT + h;
    endfunction

    task automatic goto_pos(input int target);
        while (abs_pos < target) begin
            @(posedge clk);
            #1;
            abs_pos++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hsync"}, 32'(hsync), 32'd1);
        chk({tag, "_vsync"}, 32'(vsync), 32'd1);
        chk({tag, "_display_on"}, 32'(display_on), 32'd0);
        chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, "_cell_x"}, 32'(cell_x), 32'd0);
        chk({tag, "_cell_y"}, 32'(cell_y), 32'd0);
        chk({tag, "_sub_x"}, 32'(sub_x), 32'd0);
        chk({tag, "_sub_y"}, 32'(sub_y), 32'd0);
        chk({tag, "_frame"}, 32'(frame), 32'd0);
        chk({tag, "_cfg_active"}, 32'(cfg_active), 32'd0);
        chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        int hs_low, disp_cnt, hs_first, vs_low, fs_cnt, act_cnt;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        cfg_valid   = 1'b0;
        cfg_data    = 8'h00;
        abs_pos     = -1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");

        @(negedge clk);
        rst = 1'b0;
        abs_pos = -1;

        // First edge after release shows position (0,0)
        goto_pos(0);
        chk("first_frame_start", 32'(frame_start), 32'd1);
        chk("first_display_on", 32'(display_on), 32'd1);
        goto_pos(1);
        chk("frame_start_one_cycle", 32'(frame_start), 32'd0);

        // Right edge of visible area and hsync window
        goto_pos(63);
        chk("h63_display_on", 32'(display_on), 32'd1);
        chk("h63_cell_x", 32'(cell_x), 32'd3);
        chk("h63_sub_x", 32'(sub_x), 32'd15);
        goto_pos(64);
        chk("h64_display_on", 32'(display_on), 32'd0);
        chk("h64_cell_x", 32'(cell_x), 32'd0);
        goto_pos(67);
        chk("h67_hsync", 32'(hsync), 32'd1);
        goto_pos(68);
        chk("h68_hsync", 32'(hsync), 32'd0);
        goto_pos(75);
        chk("h75_hsync", 32'(hsync), 32'd0);
        goto_pos(76);
        chk("h76_hsync", 32'(hsync), 32'd1);

        // One whole visible line: count hsync low and display_on high cycles
        hs_low = 0; disp_cnt = 0; hs_first = -1;
        goto_pos(pos(0, 2, 0) - 1);
        for (int i = 0; i < HT; i++) begin
            goto_pos(pos(0, 2, i));
            if (!hsync) begin
                if (hs_first < 0) hs_first = i;
                hs_low++;
            end
            if (display_on) disp_cnt++;
        end
        chk("line_hsync_low_cycles", 32'(hs_low), 32'(HS));
        chk("line_hsync_first_low", 32'(hs_first), 32'(HA + HF));
        chk("line_display_cycles", 32'(disp_cnt), 32'(HA));

        // Offer 0xA5 on line 10
        goto_pos(pos(0, 10, 0));
        chk("pre_offer_ready", 32'(cfg_ready), 32'd1);
        cfg_data  = 8'hA5;
        cfg_valid = 1'b1;
        goto_pos(pos(0, 10, 1));
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        chk("a5_ready_drop", 32'(cfg_ready), 32'd0);
        chk("a5_not_active_yet", 32'(cfg_active), 32'h00);

        // Pixel (37,18) and a blanked pixel on the same line
        goto_pos(pos(0, 18, 37));
        chk("px_cell_x", 32'(cell_x), 32'd2);
        chk("px_sub_x", 32'(sub_x), 32'd5);
        chk("px_cell_y", 32'(cell_y), 32'd1);
        chk("px_sub_y", 32'(sub_y), 32'd2);
        goto_pos(pos(0, 18, 70));
        chk("blank_cells", {cell_x, cell_y, sub_x, sub_y}, 32'd0);
        chk("blank_display_on", 32'(display_on), 32'd0);

        // Offer 0x3C while FULL and hold it through the boundary
        goto_pos(pos(0, 40, 0));
        cfg_data  = 8'h3C;
        cfg_valid = 1'b1;
        goto_pos(pos(0, 47, 63));
        chk("last_px_cell_x", 32'(cell_x), 32'd3);
        chk("last_px_sub_x", 32'(sub_x), 32'd15);
        chk("last_px_cell_y", 32'(cell_y), 32'd2);
        chk("last_px_sub_y", 32'(sub_y), 32'd15);
        chk("full_ignores_valid", 32'(cfg_ready), 32'd0);
        goto_pos(pos(0, 47, 79));
        chk("pre_bnd_active", 32'(cfg_active), 32'h00);
        chk("pre_bnd_frame", 32'(frame), 32'd0);
        goto_pos(pos(0, 48, 0));
        chk("bnd1_active", 32'(cfg_active), 32'hA5);
        chk("bnd1_ready", 32'(cfg_ready), 32'd1);
        chk("bnd1_frame", 32'(frame), 32'(ANIM * 1));
        goto_pos(pos(0, 48, 1));
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        chk("3c_accepted_ready", 32'(cfg_ready), 32'd0);
        chk("3c_not_bypassed", 32'(cfg_active), 32'hA5);

        // Vertical sync window
        goto_pos(pos(0, 49, 79));
        chk("v49_vsync", 32'(vsync), 32'd1);
        goto_pos(pos(0, 50, 0));
        chk("v50_vsync", 32'(vsync), 32'd0);
        goto_pos(pos(0, 51, 79));
        chk("v51_vsync", 32'(vsync), 32'd0);
        goto_pos(pos(0, 52, 0));
        chk("v52_vsync", 32'(vsync), 32'd1);

        // Frame period and second boundary
        goto_pos(pos(0, 54, 79));
        chk("frame_end_fs", 32'(frame_start), 32'd0);
        goto_pos(pos(1, 0, 0));
        chk("frame1_fs", 32'(frame_start), 32'd1);
        chk("frame1_active", 32'(cfg_active), 32'hA5);
        goto_pos(pos(1, 47, 79));
        chk("pre_bnd2_active", 32'(cfg_active), 32'hA5);
        goto_pos(pos(1, 48, 0));
        chk("bnd2_active", 32'(cfg_active), 32'h3C);
        chk("bnd2_ready", 32'(cfg_ready), 32'd1);
        chk("bnd2_frame", 32'(frame), 32'(ANIM * 2));

        // Reset mid-frame with 0x11 pending
        goto_pos(pos(2, 20, 0));
        cfg_data  = 8'h11;
        cfg_valid = 1'b1;
        goto_pos(pos(2, 20, 1));
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        chk("11_accepted", 32'(cfg_ready), 32'd0);
        goto_pos(pos(2, 30, 37));
        chk("pre_rst_display_on", 32'(display_on), 32'd1);
        chk("pre_rst_sub_y", 32'(sub_y), 32'd14);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        abs_pos = -1;

        // One full frame after reset: 0x11 must never become active
        vs_low = 0; fs_cnt = 0; act_cnt = 0;
        for (int i = 0; i < FT; i++) begin
            goto_pos(i);
            if (!vsync) vs_low++;
            if (frame_start) fs_cnt++;
            if (cfg_active != 8'h00) act_cnt++;
        end
        chk("frame_vsync_low_cycles", 32'(vs_low), 32'(VS * HT));
        chk("frame_start_count", 32'(fs_cnt), 32'd1);
        chk("discarded_never_active", 32'(act_cnt), 32'd0);
        goto_pos(pos(1, 0, 0));
        chk("post_rst_fs_period", 32'(frame_start), 32'd1);
        chk("post_rst_frame", 32'(frame), 32'(ANIM * 1));
        chk("post_rst_ready", 32'(cfg_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stitch_raster_ctrl.md
# stitch_raster_ctrl

Raster scheduler for the cross-stitch renderer. It generates 640x480@60 Hz VGA timing from a 25.175 MHz clock and splits the active area into a 40x30 grid of 16x16-pixel stitch cells. It also provides a frame counter for animation and a one-deep configuration handshake, so the pattern datapath only ever sees a configuration change at a frame boundary. It sits between the top-level IO and the stitch pattern/colour datapath.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- CELL_LOG2, 4, log2 of cell size in pixels

Ports:
- clk  in  1  pixel clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  new configuration byte offered
- cfg_data  in  8  configuration byte (palette/pattern select)
- cfg_ready  out  1  pending slot empty; a byte can be accepted
- cfg_active  out  8  configuration in force for the current frame
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- display_on  out  1  pixel is inside the visible area
- cell_x  out  6  cell column 0..39
- cell_y  out  5  cell row 0..29
- sub_x  out  4  pixel column within cell 0..15
- sub_y  out  4  pixel row within cell 0..15
- frame  out  8  frame counter
- frame_start  out  1  one-cycle pulse at the start of each frame

## Operation
- Internal counters:
  - hcount is 10 bits and runs 0..799 (H_TOTAL = 800).
  - vcount is 10 bits and runs 0..524 (V_TOTAL = 525).
  - vcount advances when hcount wraps from 799 to 0.
- Sync and display:
  - hsync is 0 for hcount in [656, 751]; 1 otherwise.
  - vsync is 0 for vcount in [490, 491]; 1 otherwise.
  - display_on = (hcount < 640) && (vcount < 480).
- Cell coordinates:
  - cell_x = hcount[9:4] and sub_x = hcount[3:0].
  - cell_y = vcount[8:4] and sub_y = vcount[3:0].
  - Outside the visible area these outputs are forced to 0.
- Frame boundary:
  - Defined as the cycle with hcount = 0 and vcount = 480 (first blanked line).
  - At the boundary: frame increments, wrapping 255 -> 0, and any pending configuration moves to cfg_active.
- frame_start pulses for the cycle with hcount = 0 and vcount = 0.
- Configuration handshake, two states:
  - EMPTY: cfg_ready = 1. cfg_valid && cfg_ready latches cfg_data into the pending register and moves to FULL.
  - FULL: cfg_ready = 0 and cfg_valid is ignored. At the frame boundary, pending is copied to cfg_active and the state returns to EMPTY.
- Accept and boundary in the same cycle (possible only in EMPTY): the byte goes to pending and is applied at the next boundary. There is no bypass into cfg_active.
- A byte offered while FULL is not consumed. The sender holds cfg_valid until cfg_ready returns.

## Timing
- All outputs are registered and show the values decoded from the counters of the previous cycle, i.e. one cycle of latency, applied uniformly.
- Reset values:
  - Counters: hcount = 0, vcount = 0.
  - hsync = 1, vsync = 1, display_on = 0, frame_start = 0.
  - cell_x, cell_y, sub_x and sub_y = 0.
  - frame = 0, cfg_active = 0, cfg_ready = 1, pending = 0, state EMPTY.
- First frame_start: the cycle after the first clock edge with rst low.
- Line period is 800 cycles; frame period is 420000 cycles.
- cfg_ready rises the cycle after the boundary. cfg_active changes on the same edge.
- Asserting rst mid-frame or mid-handshake discards the pending byte. cfg_active returns to 0 immediately (asynchronously).

## Configuration
- Macro STITCH_ANIM_EN:
  - Defined: the frame counter is implemented as described.
  - Undefined: frame is tied to 8'h00, no counter flops are built, and frame_start and the configuration logic are unchanged.

## Test plan
- Reset release, count 800 cycles: hsync low for exactly 96 cycles starting 657 cycles after release; display_on high for 640 cycles per visible line.
- Full frame: vsync low for 1600 cycles (lines 490-491); frame_start pulses every 420000 cycles; frame goes 0 -> 1 -> 2 (0 with STITCH_ANIM_EN undefined).
- Pixel (hcount 37, vcount 18): cell_x = 2, sub_x = 5, cell_y = 1, sub_y = 2. At hcount 700: all cell/sub outputs are 0.
- Offer 0xA5 at line 100: cfg_ready drops the next cycle. cfg_active stays 0x00 until boundary line 480, then becomes 0xA5 and cfg_ready returns to 1.
- Offer 0x3C while FULL holding 0xA5: not accepted. After the boundary cfg_active = 0xA5 and 0x3C is accepted; it becomes active one frame later.
- Assert rst at line 200 with pending 0x11: all outputs return to reset values; 0x11 never appears on cfg_active.
